lap_ctrl: RTL and testbench

Split-time recorder and recall sequencer for the stopwatch. It captures the live BCD time value into a small lap buffer on each debounced lap press while the timer runs. It then lets the user step through the stored laps on the display. It sits between the main stopwatch FSM/counter chain and the display driver, and selects whether the display shows live time or a recalled lap.

---
 rtl/lap_pkg.sv | 7 +
 rtl/lap_mem.sv | 19 +
 rtl/lap_ctrl.sv | 70 +++++++
 tb/tb_lap_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/lap_pkg.sv
// lap_pkg: shared types and defaults for the lap split-time recorder
package lap_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int TIME_W_DEF = 24;
  typedef enum logic {LIVE, RECALL} state_t;
  typedef logic [5:0][3:0] bcd_time_t;
endpackage

// File: rtl/lap_mem.sv
// lap_mem: DEPTH x TIME_W register file, sync write, async read, no storage reset
module lap_mem
  import lap_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [TIME_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [TIME_W-1:0]        rdata
);
  logic [TIME_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/lap_ctrl.sv
// lap_ctrl: captures lap times into a buffer and sequences their recall to the display
module lap_ctrl
  import lap_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [TIME_W-1:0]          time_i,
  input  logic                       lap_i,
  input  logic                       recall_i,
  input  logic                       clear_i,
  output logic [TIME_W-1:0]          time_o,
  output logic [$clog2(DEPTH)-1:0]   idx_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       recall_o,
  output logic                       full_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [TIME_W-1:0] time_q, time_d, rdata;
  logic full_q, full_d, cap, rec, last;
  lap_mem #(.DEPTH(DEPTH), .TIME_W(TIME_W)) u_mem (
    .clk  (clk),
    .we   (cap),
    .waddr(count_q[IW-1:0]),
    .wdata(time_i),
    .raddr(idx_q),
    .rdata(rdata)
  );
  always_comb begin
    cap     = lap_i & en_i & ~full_q & ~clear_i;
    rec     = recall_i & ~cap & ~clear_i;
    last    = CW'(idx_q) == count_q - 1'b1;
    state_d = clear_i ? LIVE
            : !rec ? state_q
            : state_q == LIVE ? (count_q != '0 ? RECALL : LIVE)
            : last ? LIVE : RECALL;
    idx_d   = clear_i ? '0
            : rec && state_q == RECALL ? (last ? '0 : idx_q + 1'b1)
            : idx_q;
    count_d = clear_i ? '0 : cap ? count_q + 1'b1 : count_q;
    full_d  = count_d == CW'(DEPTH);
    time_d  = state_q == RECALL ? rdata : time_i;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= LIVE;
      idx_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      full_q  <= full_d;
      time_q  <= time_d;
    end
  assign time_o   = time_q;
  assign idx_o    = idx_q;
  assign count_o  = count_q;
  assign recall_o = state_q == RECALL;
  assign full_o   = full_q;
endmodule

// File: tb/tb_lap_ctrl.sv
// tb_lap_ctrl: directed scoreboard bench for lap_ctrl
module tb_lap_ctrl;
  logic clk = 0, rst = 1, en_i = 0, lap_i = 0, recall_i = 0, clear_i = 0;
  logic [23:0] time_i = '0, time_o;
  logic [2:0] idx_o;
  logic [3:0] count_o;
  logic recall_o, full_o;
  int checks = 0, errors = 0;
  typedef struct {
    string nm;
    logic [23:0] t;
    int idx;
    int cnt;
    bit rec;
    bit full;
  } exp_t;
  exp_t q[$];
  lap_ctrl dut (
    .clk(clk), .rst(rst), .en_i(en_i), .time_i(time_i), .lap_i(lap_i),
    .recall_i(recall_i), .clear_i(clear_i), .time_o(time_o), .idx_o(idx_o),
    .count_o(count_o), .recall_o(recall_o), .full_o(full_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input exp_t e);
    checks += 5;
    if (time_o !== e.t) begin errors++; $display("FAIL %s time_o got %h want %h", e.nm, time_o, e.t); end
    if (idx_o !== 3'(e.idx)) begin errors++; $display("FAIL %s idx_o got %0d want %0d", e.nm, idx_o, e.idx); end
    if (count_o !== 4'(e.cnt)) begin errors++; $display("FAIL %s count_o got %0d want %0d", e.nm, count_o, e.cnt); end
    if (recall_o !== e.rec) begin errors++; $display("FAIL %s recall_o got %b want %b", e.nm, recall_o, e.rec); end
    if (full_o !== e.full) begin errors++; $display("FAIL %s full_o got %b want %b", e.nm, full_o, e.full); end
  endtask
  always @(negedge clk)
    if (q.size() > 0) chk(q.pop_front());
  task automatic cyc(input string nm, input bit en, input logic [23:0] t,
                     input bit lp, input bit rc, input bit cl,
                     input int ec, input int ei, input bit er, input bit ef,
                     input logic [23:0] et);
    en_i = en; time_i = t; lap_i = lp; recall_i = rc; clear_i = cl;
    @(posedge clk);
    q.push_back('{nm, et, ei, ec, er, ef});
    @(negedge clk);
    lap_i = 0; recall_i = 0; clear_i = 0;
  endtask
  initial begin
    #1 chk('{"reset", 24'h0, 0, 0, 0, 0});
    @(negedge clk) rst = 0;
    cyc("lap1", 1, 24'h000105, 1, 0, 0, 1, 0, 0, 0, 24'h000105);
    cyc("rec_enter", 1, 24'h000105, 0, 1, 0, 1, 0, 1, 0, 24'h000105);
    cyc("rec_show", 1, 24'h000999, 0, 0, 0, 1, 0, 1, 0, 24'h000105);
    cyc("rec_exit", 1, 24'h000999, 0, 1, 0, 1, 0, 0, 0, 24'h000105);
    cyc("clear1", 1, 24'h000000, 0, 0, 1, 0, 0, 0, 0, 24'h000000);
    cyc("lap_dis", 0, 24'h000011, 1, 0, 0, 0, 0, 0, 0, 24'h000011);
    cyc("rec_empty", 0, 24'h000022, 0, 1, 0, 0, 0, 0, 0, 24'h000022);
    cyc("live_track", 0, 24'h000033, 0, 0, 0, 0, 0, 0, 0, 24'h000033);
    for (int i = 1; i <= 8; i++)
      cyc($sformatf("fill%0d", i), 1, 24'(i), 1, 0, 0, i, 0, 0, i == 8, 24'(i));
    cyc("lap9_drop", 1, 24'h000009, 1, 0, 0, 8, 0, 0, 1, 24'h000009);
    cyc("full_enter", 1, 24'h000000, 0, 1, 0, 8, 0, 1, 1, 24'h000000);
    for (int k = 1; k <= 7; k++)
      cyc($sformatf("step%0d", k), 1, 24'h000000, 0, 1, 0, 8, k, 1, 1, 24'(k));
    cyc("full_exit", 1, 24'h000000, 0, 1, 0, 8, 0, 0, 1, 24'h000008);
    cyc("full_live", 1, 24'h000077, 0, 0, 0, 8, 0, 0, 1, 24'h000077);
    cyc("clear2", 1, 24'h000000, 0, 0, 1, 0, 0, 0, 0, 24'h000000);
    for (int i = 1; i <= 3; i++)
      cyc($sformatf("three%0d", i), 1, 24'(i), 1, 0, 0, i, 0, 0, 0, 24'(i));
    cyc("three_rec", 1, 24'h000000, 0, 1, 0, 3, 0, 1, 0, 24'h000000);
    cyc("all_three", 1, 24'h000000, 1, 1, 1, 0, 0, 0, 0, 24'h000001);
    cyc("lap_over_rec", 1, 24'h000044, 1, 1, 0, 1, 0, 0, 0, 24'h000044);
    cyc("grow_lap", 1, 24'h000055, 1, 0, 0, 2, 0, 0, 0, 24'h000055);
    cyc("grow_enter", 1, 24'h000000, 0, 1, 0, 2, 0, 1, 0, 24'h000000);
    cyc("grow_step", 1, 24'h000000, 0, 1, 0, 2, 1, 1, 0, 24'h000044);
    cyc("grow_cap", 1, 24'h000230, 1, 0, 0, 3, 1, 1, 0, 24'h000055);
    cyc("grow_step2", 1, 24'h000000, 0, 1, 0, 3, 2, 1, 0, 24'h000055);
    cyc("grow_show", 1, 24'h000000, 0, 0, 0, 3, 2, 1, 0, 24'h000230);
    cyc("clear3", 1, 24'h000000, 0, 0, 1, 0, 0, 0, 0, 24'h000230);
    for (int i = 1; i <= 5; i++)
      cyc($sformatf("five%0d", i), 1, 24'(i), 1, 0, 0, i, 0, 0, 0, 24'(i));
    cyc("five_rec", 1, 24'h000000, 0, 1, 0, 5, 0, 1, 0, 24'h000000);
    cyc("five_show", 1, 24'h000000, 0, 0, 0, 5, 0, 1, 0, 24'h000001);
    #2 rst = 1;
    #1 chk('{"async_rst", 24'h0, 0, 0, 0, 0});
    @(negedge clk) rst = 0;
    cyc("post_rst", 1, 24'h000abc, 0, 0, 0, 0, 0, 0, 0, 24'h000abc);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL drain pending %0d want 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
